l2_cache_ctrl: RTL and testbench
================================

L2_CACHE_CTRL -- requirements
Module: l2_cache_ctrl

Interface
REQ-001 Parameter N, default 32, SHALL set address/word width in bits.
REQ-002 Parameter BLOCKSIZE, default 8, SHALL set bytes per line.
REQ-003 Parameter WORDSIZE, default 4, SHALL set bytes per word; WORDSPERLINE = BLOCKSIZE/WORDSIZE.
REQ-004 Parameter NUMLINES, default 64 (power of 2), SHALL set direct-mapped line count.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high: clk input 1 (rising-edge clock), then rst input 1 (async active-high reset).
REQ-006 addr input N; request byte address from arbiter.
REQ-007 data_in input [WORDSPERLINE][N]; full line write data.
REQ-008 re input 1; request active; we input 1; request is a line write when high with re.
REQ-009 data_out output [WORDSPERLINE][N]; read line; hit output 1; request complete.
REQ-010 mem_addr output N; mem_wdata output [WORDSPERLINE][N]; mem_re, mem_we output 1; main-memory request.
REQ-011 mem_rdata input [WORDSPERLINE][N]; mem_ready input 1; main-memory completion.

Function
REQ-012 Address split SHALL be offset = log2(BLOCKSIZE) LSBs, index = next log2(NUMLINES) bits, tag = remaining MSBs.
REQ-013 FSM states SHALL be IDLE, LOOKUP, WBACK, FILL, MWRITE, DONE.
REQ-014 IDLE: re=1 at edge SHALL latch addr, data_in, we into request registers and go LOOKUP; inputs ignored thereafter until IDLE.
REQ-015 LOOKUP read hit (valid & tag match) SHALL load data_out from line and go DONE: hit high second cycle after re first sampled.
REQ-016 LOOKUP read miss SHALL go FILL (or WBACK first per REQ-031).
REQ-017 FILL SHALL drive mem_re=1, mem_addr=line-aligned request address until mem_ready; on mem_ready SHALL install mem_rdata, set valid, tag, dirty=0, set data_out=mem_rdata, go DONE.
REQ-018 LOOKUP write (hit or miss) SHALL write data_in to indexed line, set valid and tag (write-allocate, no fill), then proceed per REQ-030/REQ-032.
REQ-019 Memory handshake: mem_addr/mem_wdata SHALL be stable while mem_re or mem_we high; strobe drops the cycle after mem_ready sampled; mem_re and mem_we SHALL never be high together.
REQ-020 DONE SHALL drive hit=1 and hold data_out; SHALL return IDLE on first edge with re=0, so hit stays high while re held.
REQ-021 hit SHALL be 0 in all states except DONE; data_out SHALL be 0 outside DONE.
REQ-022 re dropping mid-operation SHALL NOT abort; operation completes, DONE lasts exactly one cycle.
REQ-023 mem_ready outside FILL/WBACK/MWRITE SHALL be ignored.
REQ-024 Back-to-back request: re still high in IDLE after DONE exit SHALL start a new LOOKUP (no lost cycle beyond IDLE).

Reset
REQ-025 rst SHALL immediately force IDLE, clear all valid and dirty bits, clear request registers.
REQ-026 During/after reset: hit, mem_re, mem_we = 0; data_out, mem_addr, mem_wdata = 0; data array contents not reset.
REQ-027 Reset mid-FILL/WBACK/MWRITE SHALL drop mem strobe asynchronously; pending memory transaction abandoned.

Configuration
REQ-028 Macro L2_WRITEBACK_EN SHALL select write policy.
REQ-029 With L2_WRITEBACK_EN: per-line dirty bit exists; MWRITE unused.
REQ-030 With L2_WRITEBACK_EN: write SHALL set dirty=1 and go DONE directly.
REQ-031 With L2_WRITEBACK_EN: any miss whose victim is valid & dirty SHALL first go WBACK, driving mem_we, mem_addr={victim tag,index,0}, mem_wdata=victim line until mem_ready, then FILL (read) or install (write).
REQ-032 Without L2_WRITEBACK_EN: no dirty storage, WBACK unused; every write SHALL go MWRITE (mem_we, request address, data_in until mem_ready) then DONE.

Structure
REQ-033 Package l2_pkg SHALL hold state enum typedef, default parameter constants, tag/index width functions.
REQ-034 Sub-module l2_line_store SHALL hold tag/valid/dirty/data arrays with one read and one write port; FSM stays in l2_cache_ctrl.

Verification
REQ-035 Cold read addr 0x100, mem_rdata={0xA,0xB}, mem_ready after 3 cycles -> mem_re held 3 cycles, hit=1, data_out={0xA,0xB}.
REQ-036 Repeat read 0x100 -> no mem_re, hit high 2 cycles after re, held until re drops.
REQ-037 Write {0x1,0x2} to 0x100 then read 0x100 -> data_out={0x1,0x2}, no memory read.
REQ-038 L2_WRITEBACK_EN: dirty 0x100 then read 0x100+NUMLINES*BLOCKSIZE -> mem_we at 0x100 with {0x1,0x2}, then mem_re at conflict address.
REQ-039 No macro: write 0x200 -> mem_we, mem_addr=0x200 until mem_ready, then hit=1.
REQ-040 rst asserted mid-FILL -> mem_re=0 same cycle; next read 0x100 misses.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types, default geometry and address-field width helpers for the L2 cache controller.
package l2_pkg;

  localparam int N_DEF         = 32;
  localparam int BLOCKSIZE_DEF = 8;
  localparam int WORDSIZE_DEF  = 4;
  localparam int NUMLINES_DEF  = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WBACK,
    FILL,
    MWRITE,
    DONE
  } state_t;

  function automatic int off_w(input int blocksize);
    return $clog2(blocksize);
  endfunction

  function automatic int idx_w(input int numlines);
    return $clog2(numlines);
  endfunction

  function automatic int tag_w(input int n, input int blocksize, input int numlines);
    return n - off_w(blocksize) - idx_w(numlines);
  endfunction

endpackage

// File: rtl/l2_cache_ctrl_if.sv
// Request-side and main-memory-side signal bundle of the L2 cache controller.
interface l2_cache_ctrl_if #(
  parameter int N   = 32,
  parameter int WPL = 2
);
  logic [N-1:0]          addr;
  logic [WPL-1:0][N-1:0] data_in;
  logic                  re;
  logic                  we;
  logic [WPL-1:0][N-1:0] data_out;
  logic                  hit;
  logic [N-1:0]          mem_addr;
  logic [WPL-1:0][N-1:0] mem_wdata;
  logic                  mem_re;
  logic                  mem_we;
  logic [WPL-1:0][N-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output addr, data_in, re, we, mem_rdata, mem_ready,
    input  data_out, hit, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport slave (
    input  addr, data_in, re, we, mem_rdata, mem_ready,
    output data_out, hit, mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/l2_line_store.sv
// Direct-mapped tag/valid/data arrays with one read and one write port.
// The per-line dirty array exists only when L2_WRITEBACK_EN is defined.
module l2_line_store #(
  parameter int N    = 32,
  parameter int WPL  = 2,
  parameter int IDXW = 6,
  parameter int TAGW = 23
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef L2_WRITEBACK_EN
  output logic                  rd_dirty_o,
  input  logic                  wr_dirty_i,
`endif
  input  logic [IDXW-1:0]       rd_idx_i,
  output logic [TAGW-1:0]       rd_tag_o,
  output logic                  rd_valid_o,
  output logic [WPL-1:0][N-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [IDXW-1:0]       wr_idx_i,
  input  logic [TAGW-1:0]       wr_tag_i,
  input  logic [WPL-1:0][N-1:0] wr_data_i
);
  localparam int NL = 1 << IDXW;

  logic [TAGW-1:0]       tag_q  [NL];
  logic [WPL-1:0][N-1:0] data_q [NL];
  logic [NL-1:0]         valid_q;

  // Tags and data are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;
  end

`ifdef L2_WRITEBACK_EN
  logic [NL-1:0] dirty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dirty_q <= '0;
    else if (wr_en_i) dirty_q[wr_idx_i] <= wr_dirty_i;
  end

  assign rd_dirty_o = dirty_q[rd_idx_i];
`endif

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/l2_cache_ctrl.sv
// Direct-mapped L2 cache controller FSM, write-allocate without fill on writes.
// L2_WRITEBACK_EN selects write-back with dirty bits; otherwise write-through via MWRITE.
module l2_cache_ctrl
  import l2_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int BLOCKSIZE = BLOCKSIZE_DEF,
  parameter int WORDSIZE  = WORDSIZE_DEF,
  parameter int NUMLINES  = NUMLINES_DEF
) (
  input logic             clk,
  input logic             rst,
  l2_cache_ctrl_if.slave  bus
);
  localparam int WPL  = BLOCKSIZE / WORDSIZE;
  localparam int OFFW = off_w(BLOCKSIZE);
  localparam int IDXW = idx_w(NUMLINES);
  localparam int TAGW = tag_w(N, BLOCKSIZE, NUMLINES);

  typedef logic [WPL-1:0][N-1:0] line_t;

  state_t         state_q, state_d;
  logic [N-1:0]   req_addr_q, req_addr_d;
  line_t          req_data_q, req_data_d;
  logic           req_we_q, req_we_d;
  line_t          dout_q, dout_d;

  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic [TAGW-1:0] rd_tag;
  logic            rd_valid;
  line_t           rd_data;
  logic            tag_hit;
  logic            wr_en;
  line_t           wr_data;

  assign req_idx = req_addr_q[OFFW +: IDXW];
  assign req_tag = req_addr_q[N-1 -: TAGW];
  assign tag_hit = rd_valid && (rd_tag == req_tag);

`ifdef L2_WRITEBACK_EN
  logic rd_dirty;
  logic wr_dirty;
  logic victim_dirty;

  // A write hit on a dirty line overwrites it in place; only a conflicting dirty line needs WBACK.
  assign victim_dirty = rd_valid && rd_dirty && !tag_hit;
`endif

  l2_line_store #(
    .N    (N),
    .WPL  (WPL),
    .IDXW (IDXW),
    .TAGW (TAGW)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
`ifdef L2_WRITEBACK_EN
    .rd_dirty_o (rd_dirty),
    .wr_dirty_i (wr_dirty),
`endif
    .rd_idx_i   (req_idx),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (req_idx),
    .wr_tag_i   (req_tag),
    .wr_data_i  (wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_we_q   <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_we_q   <= req_we_d;
      dout_q     <= dout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    req_we_d      = req_we_q;
    dout_d        = dout_q;
    wr_en         = 1'b0;
    wr_data       = req_data_q;
`ifdef L2_WRITEBACK_EN
    wr_dirty      = 1'b0;
`endif
    bus.hit       = 1'b0;
    bus.data_out  = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.re) begin
          req_addr_d = bus.addr;
          req_data_d = bus.data_in;
          req_we_d   = bus.we;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_we_q) begin
`ifdef L2_WRITEBACK_EN
          if (victim_dirty) begin
            state_d = WBACK;
          end else begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            dout_d   = req_data_q;
            state_d  = DONE;
          end
`else
          wr_en   = 1'b1;
          dout_d  = req_data_q;
          state_d = MWRITE;
`endif
        end else if (tag_hit) begin
          dout_d  = rd_data;
          state_d = DONE;
        end else begin
`ifdef L2_WRITEBACK_EN
          state_d = victim_dirty ? WBACK : FILL;
`else
          state_d = FILL;
`endif
        end
      end
`ifdef L2_WRITEBACK_EN
      WBACK: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {rd_tag, req_idx, {OFFW{1'b0}}};
        bus.mem_wdata = rd_data;
        if (bus.mem_ready) begin
          if (req_we_q) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            dout_d   = req_data_q;
            state_d  = DONE;
          end else begin
            state_d = FILL;
          end
        end
      end
`else
      MWRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = req_addr_q;
        bus.mem_wdata = req_data_q;
        if (bus.mem_ready) state_d = DONE;
      end
`endif
      FILL: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = {req_addr_q[N-1:OFFW], {OFFW{1'b0}}};
        if (bus.mem_ready) begin
          wr_en   = 1'b1;
          wr_data = bus.mem_rdata;
          dout_d  = bus.mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.hit      = 1'b1;
        bus.data_out = dout_q;
        if (!bus.re) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Scoreboard bench for l2_cache_ctrl: stimulus queues expected responses and memory
// transactions; a response monitor and a memory model pop and compare them.
module tb_l2_cache_ctrl;
  localparam int N   = 32;
  localparam int WPL = 2;

  typedef logic [WPL-1:0][N-1:0] line_t;
  typedef struct {
    line_t data;
    int    issue;
    int    lat;
    int    dur;
  } resp_t;
  typedef struct {
    logic         we;
    logic [N-1:0] addr;
    line_t        wdata;
    line_t        rdata;
    int           delay;
  } mem_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  resp_t rq[$];
  mem_t  mq[$];

  logic  ready_m = 1'b0;
  logic  ready_s = 1'b0;
  line_t rdata_m = '0;

  l2_cache_ctrl_if #(.N(N), .WPL(WPL)) bus ();

  l2_cache_ctrl #(
    .N         (N),
    .BLOCKSIZE (8),
    .WORDSIZE  (4),
    .NUMLINES  (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.mem_ready = ready_m | ready_s;
  assign bus.mem_rdata = rdata_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor
  resp_t cur_r;
  int    hcnt = 0;
  logic  hit_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hit_prev = 1'b0;
      hcnt     = 0;
    end else begin
      if (bus.hit && !hit_prev) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hit: got hit=1 expected no response (cycle %0d)", cyc);
        end else begin
          cur_r = rq.pop_front();
          chk("data_out", bus.data_out, cur_r.data);
          if (cur_r.lat >= 0) chk("hit_latency", 64'(cyc - cur_r.issue), 64'(cur_r.lat));
        end
        hcnt = 1;
      end else if (bus.hit) begin
        hcnt++;
      end else if (hit_prev) begin
        chk("hit_duration", 64'(hcnt), 64'(cur_r.dur));
        chk("dout_idle", bus.data_out, 64'h0);
      end
      hit_prev = bus.hit;
    end
  end

  // Memory model
  mem_t         cur_m;
  logic         m_active = 1'b0;
  logic         m_ok = 1'b1;
  int           m_el = 0;
  int           m_sc = 0;
  logic [N-1:0] first_addr = '0;
  line_t        first_wdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      ready_m  = 1'b0;
    end else begin
      if (ready_m) begin
        ready_m = 1'b0;
        chk("mem_strobe_cycles", 64'(m_sc), 64'(cur_m.delay));
        chk("mem_stable_excl", 64'(m_ok), 64'h1);
        m_active = 1'b0;
      end
      if (!m_active && (bus.mem_re || bus.mem_we)) begin
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got we=%0b re=%0b addr=%h expected no memory access",
                   bus.mem_we, bus.mem_re, bus.mem_addr);
          cur_m.we    = bus.mem_we;
          cur_m.addr  = bus.mem_addr;
          cur_m.wdata = '0;
          cur_m.rdata = '0;
          cur_m.delay = 1;
        end else begin
          cur_m = mq.pop_front();
          chk("mem_we", 64'(bus.mem_we), 64'(cur_m.we));
          chk("mem_addr", 64'(bus.mem_addr), 64'(cur_m.addr));
          if (cur_m.we) chk("mem_wdata", bus.mem_wdata, cur_m.wdata);
        end
        m_active    = 1'b1;
        m_el        = 0;
        m_sc        = 0;
        m_ok        = 1'b1;
        first_addr  = bus.mem_addr;
        first_wdata = bus.mem_wdata;
      end
      if (m_active) begin
        m_el++;
        if (cur_m.we ? bus.mem_we : bus.mem_re) m_sc++;
        if ((bus.mem_re && bus.mem_we) || bus.mem_addr !== first_addr || bus.mem_wdata !== first_wdata)
          m_ok = 1'b0;
        if (m_el == cur_m.delay) begin
          ready_m = 1'b1;
          rdata_m = cur_m.rdata;
        end
      end
    end
  end

  task automatic mexp(input logic w, input logic [N-1:0] a, input line_t wd, input line_t rd, input int dly);
    mem_t m;
    m.we    = w;
    m.addr  = a;
    m.wdata = wd;
    m.rdata = rd;
    m.delay = dly;
    mq.push_back(m);
  endtask

  // Inputs are scrambled after the request is latched; the cache must ignore them.
  task automatic req(input logic [N-1:0] a, input logic w, input line_t d,
                     input int hold, input int lat, input line_t exp);
    resp_t r;
    int    n;
    @(negedge clk);
    bus.addr    = a;
    bus.we      = w;
    bus.data_in = d;
    bus.re      = 1'b1;
    r.data  = exp;
    r.issue = cyc;
    r.lat   = lat;
    r.dur   = hold + 1;
    rq.push_back(r);
    @(negedge clk);
    bus.addr    = ~a;
    bus.data_in = ~d;
    bus.we      = ~w;
    n = 1;
    while (!bus.hit && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("req_complete", 64'(bus.hit), 64'h1);
    repeat (hold) @(negedge clk);
    bus.re      = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
  endtask

  line_t la, lw1, lw3, lc, le, lf, lx;

  initial begin
    int n;
    la  = {32'hA, 32'hB};
    lw1 = {32'h1, 32'h2};
    lw3 = {32'h33, 32'h44};
    lc  = {32'hC, 32'hD};
    le  = {32'hE, 32'hF};
    lf  = {32'h77, 32'h88};
    lx  = {32'h55, 32'h66};
    bus.re      = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;

    repeat (3) @(negedge clk);
    chk("rst_hit", 64'(bus.hit), 64'h0);
    chk("rst_mem_re", 64'(bus.mem_re), 64'h0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'h0);
    chk("rst_data_out", bus.data_out, 64'h0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'h0);
    rst = 1'b0;

    // Cold read miss, memory answers after 3 strobe cycles
    mexp(1'b0, 32'h100, '0, la, 3);
    req(32'h100, 1'b0, '0, 0, -1, la);

    // Repeat read hits; stray mem_ready must be ignored
    ready_s = 1'b1;
    req(32'h100, 1'b0, '0, 2, 2, la);
    ready_s = 1'b0;

`ifdef L2_WRITEBACK_EN
    req(32'h100, 1'b1, lw1, 0, 2, lw1);
`else
    mexp(1'b1, 32'h100, lw1, '0, 2);
    req(32'h100, 1'b1, lw1, 0, -1, lw1);
`endif
    req(32'h104, 1'b0, '0, 1, 2, lw1);

`ifdef L2_WRITEBACK_EN
    req(32'h200, 1'b1, lw3, 0, 2, lw3);
    mexp(1'b1, 32'h100, lw1, '0, 2);
`else
    mexp(1'b1, 32'h200, lw3, '0, 4);
    req(32'h200, 1'b1, lw3, 0, -1, lw3);
`endif

    // Conflict miss on index 32
    mexp(1'b0, 32'h300, '0, lc, 2);
    req(32'h300, 1'b0, '0, 0, -1, lc);
    mexp(1'b0, 32'h100, '0, le, 1);
    req(32'h100, 1'b0, '0, 0, -1, le);

    // Reset in the middle of a fill
    mexp(1'b0, 32'h508, '0, lx, 30);
    @(negedge clk);
    bus.addr = 32'h508;
    bus.we   = 1'b0;
    bus.re   = 1'b1;
    n = 0;
    while (!bus.mem_re && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("fill_started", 64'(bus.mem_re), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_fill_mem_re", 64'(bus.mem_re), 64'h0);
    chk("rst_fill_mem_we", 64'(bus.mem_we), 64'h0);
    chk("rst_fill_hit", 64'(bus.hit), 64'h0);
    chk("rst_fill_mem_addr", 64'(bus.mem_addr), 64'h0);
    bus.re = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Valid bits were cleared, so this misses again
    mexp(1'b0, 32'h100, '0, lf, 2);
    req(32'h100, 1'b0, '0, 0, -1, lf);
    req(32'h100, 1'b0, '0, 0, 2, lf);

    repeat (5) @(negedge clk);
    chk("resp_queue_empty", 64'(rq.size()), 64'h0);
    chk("mem_queue_empty", 64'(mq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
